sar_result_buffer: RTL

//  Downstream stage of the SAR converter. Captures each 8-bit conversion result on the

---
 rtl/sar_adc_pkg.sv | 27 ++
 rtl/sar_sync_fifo.sv | 89 ++++++++
 rtl/sar_result_buffer.sv | 105 ++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// Shared SAR converter definitions: converter word width and width helpers
// used by the result buffer and its FIFO.
package sar_adc_pkg;

    localparam int ADC_W = 8;

    // Encodes {write, read} so the FIFO bookkeeping can be one case statement.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// Show-ahead synchronous FIFO with explicit level count and synchronous flush.
// A push while full is accepted only when a pop frees the head slot that cycle.
module sar_sync_fifo
    import sar_adc_pkg::*;
#(
    parameter  int W     = ADC_W,
    parameter  int DEPTH = 8,
    localparam int PTR_W = clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             clear,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_en;
    logic             wr_en;
    fifo_op_e         op;

    assign full   = (level_q == LVL_W'(DEPTH));
    assign empty  = (level_q == '0);
    assign pop_en = pop && !empty;
    assign wr_en  = push && (!full || pop_en);
    assign op     = fifo_op_e'({wr_en, pop_en});

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            case (op)
                FIFO_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    level_d  = level_q + LVL_W'(1);
                end
                FIFO_POP: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    level_d  = level_q - LVL_W'(1);
                end
                FIFO_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the level count decides which words are live.
    always_ff @(posedge clk) begin
        if (reset_in && !clear && wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Force zero when empty so stale storage never reaches the output.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/sar_result_buffer.sv
// Captures SAR results on the rising edge of the valid strobe, block-averages
// 2^AVG_LOG2 of them and queues the averages for a valid/ready consumer.
module sar_result_buffer
    import sar_adc_pkg::*;
#(
    parameter  int DATA_W   = ADC_W,
    parameter  int AVG_LOG2 = 2,
    parameter  int DEPTH    = 8,
    localparam int LVL_W    = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              valid_in,
    input  logic              clear,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic              overflow
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    // Keep the counter at least one bit wide; in pass-through it simply stays at zero.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

    logic              valid_dly_q, valid_dly_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;

    logic              sample;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] avg;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign sample = valid_in && !valid_dly_q;
    assign sum    = acc_q + ACC_W'(result_in);
    assign avg    = DATA_W'(sum >> AVG_LOG2);
    assign pop    = out_ready && !fifo_empty;

    always_comb begin
        valid_dly_d = valid_in;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        if (clear) begin
            acc_d      = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (sample) begin
            if (cnt_q != CNT_MAX) begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
                // The FIFO drops the word itself; only the sticky flag lives here.
                if (fifo_full && !pop) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            valid_dly_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            valid_dly_q <= valid_dly_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    sar_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_in  (reset_in),
        .clear     (clear),
        .push      (push),
        .push_data (avg),
        .pop       (pop),
        .head      (out_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule
